frog_judge: RTL and testbench

FROG_JUDGE -- requirements
Module: frog_judge

---
 rtl/frog_judge.sv | 175 +++++++++++++++++
 tb/tb_frog_judge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_judge.sv
// Frogger rules referee: judges death/win per frame, tracks lives, home slots
// and the per-life timer, and forwards log carry to the frog position logic.
module frog_judge #(
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned TIME_LIMIT = 1800,
  parameter int unsigned DIE_HOLD   = 60,
  parameter int unsigned WATER_YMIN = 72,
  parameter int unsigned WATER_YMAX = 216,
  parameter int unsigned HOME_Y     = 24
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [7:0]        counter,
  input  logic              unpaused,
  input  logic              manualreset,
  input  logic              hazard,
  input  logic              on_log,
  input  logic signed [9:0] log_dx,
  output logic signed [9:0] carry_dx,
  output logic              dead,
  output logic              win,
  output logic [1:0]        lives,
  output logic [4:0]        home_filled,
  output logic [10:0]       time_left,
  output logic              game_over
);

  localparam int unsigned XW = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned TW = 11;
  localparam int unsigned HW = (DIE_HOLD > 0) ? $clog2(DIE_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    S_PLAY     = 2'd0,
    S_DYING    = 2'd1,
    S_WIN_HOLD = 2'd2,
    S_OVER     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LW-1:0]        r_lives;
  logic [SW-1:0]        r_home;
  logic [TW-1:0]        r_time;
  logic [HW-1:0]        r_hold;
  logic signed [XW-1:0] r_carry;
  logic                 r_dead;
  logic                 r_win;

  logic                 w_landed;
  logic                 w_in_water;
  logic                 w_home_row;
  logic [SW-1:0]        w_slot_hit;
  logic                 w_die_cond;
  logic                 w_win_cond;
  logic                 w_hold_done;
  logic                 w_die;
  logic                 w_win;
  logic signed [XW-1:0] w_carry_nxt;

  // Playfield geometry decode
  assign w_landed      = (counter == CW'(0)) || (counter > CW'(15));
  assign w_in_water    = (BallY >= XW'(WATER_YMIN)) && (BallY <= XW'(WATER_YMAX));
  assign w_home_row    = (BallY == XW'(HOME_Y));
  assign w_slot_hit[0] = (BallX >= XW'(63))  && (BallX <= XW'(90));
  assign w_slot_hit[1] = (BallX >= XW'(178)) && (BallX <= XW'(205));
  assign w_slot_hit[2] = (BallX >= XW'(295)) && (BallX <= XW'(323));
  assign w_slot_hit[3] = (BallX >= XW'(411)) && (BallX <= XW'(439));
  assign w_slot_hit[4] = (BallX >= XW'(527)) && (BallX <= XW'(555));

  // Slots never overlap, so "no free slot hit" covers both a miss and a filled slot
  assign w_die_cond = (w_landed && hazard)
                   || (w_landed && w_in_water && !on_log)
                   || (w_in_water && ((BallX < XW'(4)) || (BallX > XW'(635))))
                   || (w_landed && w_home_row && ((w_slot_hit & ~r_home) == '0))
                   || (r_time == '0);
  assign w_win_cond  = w_landed && w_home_row && ((w_slot_hit & ~r_home) != '0);
  assign w_hold_done = (r_hold <= HW'(1));

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_PLAY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_die       = 1'b0;
    w_win       = 1'b0;
    case (r_state)
      S_PLAY: begin
        if (unpaused && w_die_cond) begin
          w_die       = 1'b1;
          w_state_nxt = S_DYING;
        end else if (unpaused && w_win_cond) begin
          w_win       = 1'b1;
          w_state_nxt = S_WIN_HOLD;
        end
      end
      S_DYING:    if (w_hold_done) w_state_nxt = (r_lives == '0) ? S_OVER : S_PLAY;
      S_WIN_HOLD: if (w_hold_done) w_state_nxt = S_PLAY;
      default:    w_state_nxt = S_OVER;
    endcase
    if (manualreset) begin
      w_state_nxt = S_PLAY;
      w_die       = 1'b0;
      w_win       = 1'b0;
    end
  end

  always_comb begin
    game_over   = (r_state == S_OVER);
    w_carry_nxt = '0;
    if ((r_state == S_PLAY) && unpaused && on_log && w_in_water) w_carry_nxt = log_dx;
  end

  // Lives, home slots, life timer, hold counter and event pulses
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lives <= LW'(LIVES_INIT);
      r_home  <= '0;
      r_time  <= TW'(TIME_LIMIT);
      r_hold  <= '0;
      r_carry <= '0;
      r_dead  <= 1'b0;
      r_win   <= 1'b0;
    end else if (manualreset) begin
      r_lives <= LW'(LIVES_INIT);
      r_home  <= '0;
      r_time  <= TW'(TIME_LIMIT);
      r_hold  <= '0;
      r_carry <= '0;
      r_dead  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_dead  <= w_die;
      r_win   <= w_win;
      r_carry <= w_carry_nxt;
      case (r_state)
        S_PLAY: begin
          if (w_die) begin
            r_lives <= (r_lives == '0) ? '0 : r_lives - LW'(1);
            r_hold  <= HW'(DIE_HOLD);
          end else if (w_win) begin
            r_home <= r_home | w_slot_hit;
            r_hold <= HW'(DIE_HOLD);
          end else if (unpaused) begin
            r_time <= r_time - TW'(1);
          end
        end
        S_DYING, S_WIN_HOLD: begin
          if (w_hold_done) begin
            r_hold <= '0;
            r_time <= TW'(TIME_LIMIT);
            if ((r_state == S_WIN_HOLD) && (r_home == '1)) r_home <= '0;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        default: r_hold <= '0;
      endcase
    end
  end

  assign lives       = r_lives;
  assign home_filled = r_home;
  assign time_left   = r_time;
  assign carry_dx    = r_carry;
  assign dead        = r_dead;
  assign win         = r_win;

endmodule

// File: tb/tb_frog_judge.sv
// Scoreboard bench for frog_judge: a frame-level rules model predicts every
// registered output; a monitor compares each frame after the clock edge.
module tb_frog_judge;

  logic              frame_clk;
  logic              Reset_n;
  logic [9:0]        BallX;
  logic [9:0]        BallY;
  logic [7:0]        counter;
  logic              unpaused;
  logic              manualreset;
  logic              hazard;
  logic              on_log;
  logic signed [9:0] log_dx;
  logic signed [9:0] carry_dx;
  logic              dead;
  logic              win;
  logic [1:0]        lives;
  logic [4:0]        home_filled;
  logic [10:0]       time_left;
  logic              game_over;

  frog_judge dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .BallX(BallX), .BallY(BallY),
    .counter(counter), .unpaused(unpaused), .manualreset(manualreset),
    .hazard(hazard), .on_log(on_log), .log_dx(log_dx), .carry_dx(carry_dx),
    .dead(dead), .win(win), .lives(lives), .home_filled(home_filled),
    .time_left(time_left), .game_over(game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int dead_e;
    int win_e;
    int lives_e;
    int home_e;
    int time_e;
    int carry_e;
    int over_e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Game model: mode 0 play, 1 dying, 2 win hold, 3 game over
  int m_mode, m_lives, m_time, m_hold, m_carry, m_dead, m_win;
  bit [4:0] m_home;
  int slot_lo[5];
  int slot_hi[5];

  task automatic model_reset();
    m_mode = 0; m_lives = 3; m_time = 1800; m_hold = 0;
    m_carry = 0; m_dead = 0; m_win = 0; m_home = '0;
  endtask

  task automatic model_step(input int x, input int y, input int cnt, input bit unp,
                            input bit mr, input bit hz, input bit ol, input int ldx,
                            input bit rst);
    bit landed, water, home_row, die;
    int slot;
    if (!rst || mr) begin
      model_reset();
      return;
    end
    landed   = (cnt == 0) || (cnt > 15);
    water    = (y >= 72) && (y <= 216);
    home_row = (y == 24);
    slot = -1;
    for (int i = 0; i < 5; i++) if (x >= slot_lo[i] && x <= slot_hi[i]) slot = i;
    m_dead  = 0;
    m_win   = 0;
    m_carry = (m_mode == 0 && unp && ol && water) ? ldx : 0;
    if (m_mode == 0) begin
      if (unp) begin
        die = (landed && hz) || (landed && water && !ol) ||
              (water && (x < 4 || x > 635)) ||
              (landed && home_row && (slot < 0 || m_home[slot])) ||
              (m_time == 0);
        if (die) begin
          m_dead  = 1;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_mode  = 1;
          m_hold  = 60;
        end else if (landed && home_row) begin
          m_home[slot] = 1'b1;
          m_win  = 1;
          m_mode = 2;
          m_hold = 60;
        end else begin
          m_time = m_time - 1;
        end
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) begin
        m_time = 1800;
        if (m_mode == 2) begin
          if (m_home == 5'b11111) m_home = '0;
          m_mode = 0;
        end else begin
          m_mode = (m_lives == 0) ? 3 : 0;
        end
      end
    end
  endtask

  task automatic frame(input int x, input int y, input int cnt, input bit unp,
                       input bit mr, input bit hz, input bit ol, input int ldx,
                       input bit rst);
    exp_t e;
    @(negedge frame_clk);
    BallX = 10'(x); BallY = 10'(y); counter = 8'(cnt); unpaused = unp;
    manualreset = mr; hazard = hz; on_log = ol; log_dx = 10'(ldx); Reset_n = rst;
    model_step(x, y, cnt, unp, mr, hz, ol, ldx, rst);
    e.dead_e = m_dead; e.win_e = m_win; e.lives_e = m_lives; e.home_e = int'(m_home);
    e.time_e = m_time; e.carry_e = m_carry; e.over_e = (m_mode == 3) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic go(input int x, input int y, input int cnt, input bit hz,
                    input bit ol, input int ldx);
    frame(x, y, cnt, 1'b1, 1'b0, hz, ol, ldx, 1'b1);
  endtask

  task automatic safe(input int n);
    for (int i = 0; i < n; i++) go(320, 400, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic mreset();
    frame(320, 400, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one transaction per frame, sampled after the active edge
  exp_t me;
  always @(posedge frame_clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("dead", int'(dead), me.dead_e);
      chk("win", int'(win), me.win_e);
      chk("lives", int'(lives), me.lives_e);
      chk("home_filled", int'(home_filled), me.home_e);
      chk("time_left", int'(time_left), me.time_e);
      chk("carry_dx", int'(carry_dx), me.carry_e);
      chk("game_over", int'(game_over), me.over_e);
    end
  end

  int ys[10];
  int xs[14];
  int cs[7];
  int slot_c[5];

  initial begin
    slot_lo = '{63, 178, 295, 411, 527};
    slot_hi = '{90, 205, 323, 439, 555};
    ys = '{24, 24, 60, 71, 72, 120, 216, 217, 400, 300};
    xs = '{2, 4, 63, 90, 91, 178, 205, 300, 323, 439, 527, 555, 635, 636};
    cs = '{0, 0, 0, 5, 15, 16, 200};
    slot_c = '{63, 205, 309, 439, 527};
    model_reset();
    Reset_n = 1'b0; BallX = '0; BallY = '0; counter = '0; unpaused = 1'b0;
    manualreset = 1'b0; hazard = 1'b0; on_log = 1'b0; log_dx = '0;

    frame(320, 400, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    frame(320, 400, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    safe(3);
    // drowning, then respawn
    go(320, 120, 0, 1'b0, 1'b0, 0);
    safe(62);
    // riding a log, airborne over water, then landing without a log
    for (int i = 0; i < 3; i++) go(320, 120, 0, 1'b0, 1'b1, -2);
    for (int i = 0; i < 4; i++) go(320, 120, 10, 1'b0, 1'b0, 0);
    go(320, 120, 0, 1'b0, 1'b0, 0);
    safe(62);
    // same home slot twice
    mreset();
    go(300, 24, 0, 1'b0, 1'b0, 0);
    safe(62);
    go(300, 24, 0, 1'b0, 1'b0, 0);
    safe(62);
    // fill all five slots (slot edges included)
    mreset();
    for (int s = 0; s < 5; s++) begin
      go(slot_c[s], 24, 0, 1'b0, 1'b0, 0);
      safe(62);
    end
    go(91, 24, 0, 1'b0, 1'b0, 0);
    safe(62);
    go(76, 24, 0, 1'b1, 1'b0, 0);
    safe(62);
    // three deaths to game over, then restart
    mreset();
    for (int d = 0; d < 3; d++) begin
      go(320, 300, 0, 1'b1, 1'b0, 0);
      safe(62);
    end
    safe(5);
    mreset();
    safe(3);
    // pause, then run out the clock
    for (int i = 0; i < 100; i++) frame(320, 400, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    safe(1900);
    // water band and edge boundaries, reset during the hold states
    mreset();
    go(320, 71, 0, 1'b0, 1'b0, 0);
    go(320, 217, 0, 1'b0, 1'b0, 0);
    go(4, 100, 0, 1'b0, 1'b1, 3);
    go(635, 100, 0, 1'b0, 1'b1, -3);
    go(2, 100, 0, 1'b0, 1'b1, 3);
    safe(62);
    go(320, 72, 0, 1'b0, 1'b0, 0);
    safe(10);
    frame(320, 400, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    safe(3);
    go(300, 24, 0, 1'b0, 1'b0, 0);
    safe(10);
    frame(320, 400, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    safe(3);
    // randomized play
    for (int i = 0; i < 2500; i++) begin
      int x, y;
      x = ($urandom % 2 == 0) ? xs[$urandom_range(0, 13)] : int'($urandom_range(0, 639));
      y = ($urandom % 4 == 0) ? int'($urandom_range(0, 479)) : ys[$urandom_range(0, 9)];
      frame(x, y, cs[$urandom_range(0, 6)], ($urandom % 8) != 0, ($urandom % 64) == 0,
            ($urandom % 10) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)) - 8, ($urandom % 200) != 0);
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge frame_clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
